// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// One bit per cycle: shift-add multiply, restoring divide.
module ex_muldiv #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   opd_q;
   logic [2*XLEN-1:0] acc_q;
   logic              neg_q;
   logic [CW-1:0]     cnt_q;
   logic              busy_q;
   logic [XLEN-1:0]   res_q;
   logic [4:0]        rdo_q;

   logic              sgn_a, sgn_b, sa, sb;
   logic              is_div, b_zero, ovf, special, accept;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     msum;
   logic [XLEN:0]     shl;
   logic [XLEN-1:0]   sub;
   logic              ge;
   logic [2*XLEN-1:0] mul_nxt, div_nxt;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   half, fin;

   always_comb begin
      sgn_a   = (funct3 == 3'd1) | (funct3 == 3'd2)
              | (funct3 == 3'd4) | (funct3 == 3'd6);
      sgn_b   = (funct3 == 3'd1) | (funct3 == 3'd4)
              | (funct3 == 3'd6);
      sa      = sgn_a & op_a[XLEN-1];
      sb      = sgn_b & op_b[XLEN-1];
      mag_a   = sa ? -op_a : op_a;
      mag_b   = sb ? -op_b : op_b;
      is_div  = funct3[2];
      b_zero  = (op_b == '0);
      ovf     = !funct3[0]
              & (op_a == {1'b1, {(XLEN-1){1'b0}}})
              & (op_b == '1);
      special = is_div & (b_zero | ovf);
      accept  = (state == IDLE) & start & !flush;
   end

   // multiplier lives in the low half and is consumed from bit 0
   always_comb begin
      msum    = {1'b0, acc_q[2*XLEN-1:XLEN]}
              + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_nxt = {msum, acc_q[XLEN-1:1]};
   end

   // remainder in the high half, dividend/quotient in the low half
   always_comb begin
      shl     = acc_q[2*XLEN-1:XLEN-1];
      ge      = shl >= {1'b0, opd_q};
      sub     = shl[XLEN-1:0] - opd_q;
      div_nxt = ge ? {sub, acc_q[XLEN-2:0], 1'b1}
                   : {shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   always_comb begin
      prod_s = neg_q ? -acc_q : acc_q;
      half   = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      fin    = '0;
      if (op_q[2])
         fin = neg_q ? -half : half;
      else if (op_q[1:0] == 2'd0)
         fin = prod_s[XLEN-1:0];
      else
         fin = prod_s[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = busy_q;
      done   = (state == DONE) & !flush;
      stall  = !flush & ((busy_q & !done) | accept);
      result = done ? fin : res_q;
      rd_out = done ? rd_q : rdo_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         op_q   <= '0;
         rd_q   <= '0;
         opd_q  <= '0;
         acc_q  <= '0;
         neg_q  <= 1'b0;
         cnt_q  <= '0;
         res_q  <= '0;
         rdo_q  <= '0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt != IDLE);
         if (accept) begin
            op_q  <= funct3;
            rd_q  <= rd_in;
            cnt_q <= CW'(XLEN-1);
            if (special) begin
               // both halves preloaded so the common result mux applies
               opd_q <= '0;
               neg_q <= 1'b0;
               acc_q <= b_zero ? {op_a, {XLEN{1'b1}}}
                               : {{XLEN{1'b0}}, op_a};
            end else if (is_div) begin
               opd_q <= mag_b;
               acc_q <= {{XLEN{1'b0}}, mag_a};
               neg_q <= funct3[1] ? sa : (sa ^ sb);
            end else begin
               opd_q <= mag_a;
               acc_q <= {{XLEN{1'b0}}, mag_b};
               neg_q <= sa ^ sb;
            end
         end else if (state == CALC) begin
            acc_q <= op_q[2] ? div_nxt : mul_nxt;
            cnt_q <= cnt_q - CW'(1);
         end
         if (done) begin
            res_q <= fin;
            rdo_q <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv.
// Expected values are hand-computed constants.
module tb_ex_muldiv;

   logic        clk;
   logic        reset;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [4:0]  rd_in;
   logic        stall;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic [4:0]  rd_out;

   int n_chk;
   int n_fail;
   logic [63:0] last_res;

   ex_muldiv #(.XLEN(64)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .rd_in  (rd_in),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] exp,
                         input int exp_lat, input bit hold);
      int lat;
      int stl;
      bit seen;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      rd_in  = rd;
      start  = 1'b1;
      #1;
      stl = stall ? 1 : 0;
      tick();
      if (!hold) start = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (lat < 200) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (stall) stl++;
         tick();
         lat++;
      end
      start = 1'b0;
      expect_eq({tag, "_done"}, 64'(seen), 64'd1);
      expect_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      expect_eq({tag, "_res"}, result, exp);
      expect_eq({tag, "_rd"}, 64'(rd_out), 64'(rd));
      expect_eq({tag, "_stalls"}, 64'(stl), 64'(exp_lat));
      expect_eq({tag, "_stall_done"}, 64'(stall), 64'd0);
      tick();
      expect_eq({tag, "_pulse"}, 64'(done), 64'd0);
      expect_eq({tag, "_hold"}, result, exp);
      expect_eq({tag, "_busy"}, 64'(busy), 64'd0);
      last_res = exp;
   endtask

   initial begin
      bit seen;
      n_chk    = 0;
      n_fail   = 0;
      last_res = 64'd0;
      reset    = 1'b1;
      start    = 1'b0;
      flush    = 1'b0;
      funct3   = 3'd0;
      op_a     = 64'd0;
      op_b     = 64'd0;
      rd_in    = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      expect_eq("rst_busy", 64'(busy), 64'd0);
      expect_eq("rst_done", 64'(done), 64'd0);
      expect_eq("rst_res", result, 64'd0);
      expect_eq("rst_rd", 64'(rd_out), 64'd0);
      expect_eq("rst_stall", 64'(stall), 64'd0);

      run_op("mulhu", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 5'd1,
             64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
      run_op("mul", 3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd5,
             64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1);
      run_op("div", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6,
             64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);
      run_op("rem", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7,
             64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
      run_op("remu0", 3'd7, 64'd7, 64'd0, 5'd8,
             64'd7, 1, 1'b0);
      run_op("divovf", 3'd4, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
             64'h8000_0000_0000_0000, 1, 1'b0);
      run_op("divu0", 3'd5, 64'd12345, 64'd0, 5'd10,
             64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
      run_op("mulh", 3'd1, 64'h8000_0000_0000_0000,
             64'h8000_0000_0000_0000, 5'd11,
             64'h4000_0000_0000_0000, 65, 1'b0);
      run_op("mulhsu", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd12,
             64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
      run_op("divu", 3'd5, 64'd100, 64'd3, 5'd13,
             64'd33, 65, 1'b0);
      run_op("remneg", 3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd14,
             64'd1, 65, 1'b0);
      run_op("divneg", 3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd15,
             64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0);

      // flush at CALC cycle 30 of DIVU 100/3
      funct3 = 3'd5;
      op_a   = 64'd100;
      op_b   = 64'd3;
      rd_in  = 5'd16;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (29) tick();
      expect_eq("fl_busy_pre", 64'(busy), 64'd1);
      flush = 1'b1;
      #1;
      expect_eq("fl_stall", 64'(stall), 64'd0);
      expect_eq("fl_done", 64'(done), 64'd0);
      tick();
      flush = 1'b0;
      expect_eq("fl_busy", 64'(busy), 64'd0);
      expect_eq("fl_res_held", result, last_res);
      seen = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         tick();
      end
      expect_eq("fl_nodone", 64'(seen), 64'd0);
      run_op("mul42", 3'd0, 64'd6, 64'd7, 5'd17, 64'd42, 65, 1'b0);

      // start and flush together
      funct3 = 3'd0;
      op_a   = 64'd3;
      op_b   = 64'd3;
      rd_in  = 5'd18;
      start  = 1'b1;
      flush  = 1'b1;
      #1;
      expect_eq("sf_stall", 64'(stall), 64'd0);
      tick();
      start = 1'b0;
      flush = 1'b0;
      expect_eq("sf_busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (70) begin
         if (done) seen = 1'b1;
         tick();
      end
      expect_eq("sf_nodone", 64'(seen), 64'd0);
      expect_eq("sf_res", result, 64'd42);

      // reset in the middle of CALC
      funct3 = 3'd0;
      op_a   = 64'd5;
      op_b   = 64'd5;
      rd_in  = 5'd19;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_eq("mr_busy", 64'(busy), 64'd0);
      expect_eq("mr_done", 64'(done), 64'd0);
      expect_eq("mr_res", result, 64'd0);
      expect_eq("mr_rd", 64'(rd_out), 64'd0);
      expect_eq("mr_stall", 64'(stall), 64'd0);
      seen = 1'b0;
      repeat (70) begin
         if (done) seen = 1'b1;
         tick();
      end
      expect_eq("mr_nodone", 64'(seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
